// File: rtl/stg_wb_rq_pkg.sv
// rtl/stg_wb_rq_pkg.sv - shared widths and GP source select for the writeback stage
package stg_wb_rq_pkg;

    localparam int SIZE_DATA   = 24;
    localparam int SIZE_ADDR   = 24;
    localparam int SIZE_OPC    = 6;
    localparam int SIZE_TGT_GP = 3;
    localparam int SIZE_TGT_SR = 2;
    localparam int SIZE_TGT_AR = 2;

    localparam int WB_RQ_DEPTH = 4;

    // Which source owns the single GP write port this cycle
    typedef enum logic [1:0] {
        GP_SRC_NONE = 2'd0,
        GP_SRC_LD   = 2'd1,
        GP_SRC_Q    = 2'd2,
        GP_SRC_PIPE = 2'd3
    } gp_src_e;

endpackage

// File: rtl/stg_wb_rq_if.sv
// rtl/stg_wb_rq_if.sv - MEM-to-WB handshake and load-return bundle
interface stg_wb_rq_if
    import stg_wb_rq_pkg::*;
#(
    parameter int DATA_W   = SIZE_DATA,
    parameter int ADDR_W   = SIZE_ADDR,
    parameter int OPC_W    = SIZE_OPC,
    parameter int GP_TGT_W = SIZE_TGT_GP,
    parameter int SR_TGT_W = SIZE_TGT_SR,
    parameter int AR_TGT_W = SIZE_TGT_AR
);
    logic                iw_valid;
    logic                ow_ready;
    logic [ADDR_W-1:0]   iw_pc;
    logic [DATA_W-1:0]   iw_instr;
    logic [OPC_W-1:0]    iw_opc;
    logic [GP_TGT_W-1:0] iw_tgt_gp;
    logic                iw_tgt_gp_we;
    logic [SR_TGT_W-1:0] iw_tgt_sr;
    logic                iw_tgt_sr_we;
    logic [AR_TGT_W-1:0] iw_tgt_ar;
    logic                iw_tgt_ar_we;
    logic [DATA_W-1:0]   iw_result;
    logic [ADDR_W-1:0]   iw_sr_result;
    logic [ADDR_W-1:0]   iw_ar_result;
    logic                iw_ld_valid;
    logic [GP_TGT_W-1:0] iw_ld_tgt;
    logic [DATA_W-1:0]   iw_ld_data;

    modport master (
        output iw_valid, iw_pc, iw_instr, iw_opc,
               iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr, iw_tgt_sr_we, iw_tgt_ar, iw_tgt_ar_we,
               iw_result, iw_sr_result, iw_ar_result,
               iw_ld_valid, iw_ld_tgt, iw_ld_data,
        input  ow_ready
    );

    modport slave (
        input  iw_valid, iw_pc, iw_instr, iw_opc,
               iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr, iw_tgt_sr_we, iw_tgt_ar, iw_tgt_ar_we,
               iw_result, iw_sr_result, iw_ar_result,
               iw_ld_valid, iw_ld_tgt, iw_ld_data,
        output ow_ready
    );

endinterface

// File: rtl/wb_gp_fifo.sv
// rtl/wb_gp_fifo.sv - circular FIFO of displaced GP writes with per-entry targets
module wb_gp_fifo #(
    parameter int DEPTH  = 4,
    parameter int TGT_W  = 3,
    parameter int DATA_W = 24,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        push_i,
    input  logic [TGT_W-1:0]            push_tgt_i,
    input  logic [DATA_W-1:0]           push_data_i,
    input  logic                        pop_i,
    output logic [TGT_W-1:0]            head_tgt_o,
    output logic [DATA_W-1:0]           head_data_o,
    output logic [CW-1:0]               count_o,
    output logic [DEPTH-1:0]            ent_valid_o,
    output logic [DEPTH-1:0][TGT_W-1:0] ent_tgt_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]                head_q, head_d;
    logic [PW-1:0]                tail_q, tail_d;
    logic [CW-1:0]                count_q, count_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][TGT_W-1:0]  tgt_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;

    // Next-state for pointers, occupancy and valid bits; pointers wrap naturally
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (pop_i) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push_i) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    // Control state, cleared asynchronously so queued writes are dropped on reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage needs no reset; the valid bits qualify it
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            tgt_q[tail_q]  <= push_tgt_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    assign head_tgt_o  = tgt_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;
    assign ent_valid_o = valid_q;
    assign ent_tgt_o   = tgt_q;

endmodule

// File: rtl/stg_wb_rq.sv
// rtl/stg_wb_rq.sv - writeback stage with GP retire queue behind a load-return port
module stg_wb_rq
    import stg_wb_rq_pkg::*;
#(
    parameter int DATA_W   = SIZE_DATA,
    parameter int ADDR_W   = SIZE_ADDR,
    parameter int OPC_W    = SIZE_OPC,
    parameter int GP_TGT_W = SIZE_TGT_GP,
    parameter int SR_TGT_W = SIZE_TGT_SR,
    parameter int AR_TGT_W = SIZE_TGT_AR,
    parameter int DEPTH    = WB_RQ_DEPTH
) (
    input  logic                       iw_clk,
    input  logic                       iw_rst_n,
    stg_wb_rq_if.slave                 mem,
    output logic [GP_TGT_W-1:0]        ow_gp_write_addr,
    output logic [DATA_W-1:0]          ow_gp_write_data,
    output logic                       ow_gp_write_enable,
    output logic [SR_TGT_W-1:0]        ow_sr_write_addr,
    output logic [ADDR_W-1:0]          ow_sr_write_data,
    output logic                       ow_sr_write_enable,
    output logic [AR_TGT_W-1:0]        ow_ar_write_addr,
    output logic [ADDR_W-1:0]          ow_ar_write_data,
    output logic                       ow_ar_write_enable,
    output logic [2**GP_TGT_W-1:0]     ow_gp_pend,
    output logic [$clog2(DEPTH):0]     ow_q_count,
    output logic                       ow_retire_valid,
    output logic [ADDR_W-1:0]          ow_pc,
    output logic [DATA_W-1:0]          ow_instr,
    output logic [OPC_W-1:0]           ow_opc,
    output logic [GP_TGT_W-1:0]        ow_tgt_gp,
    output logic [SR_TGT_W-1:0]        ow_tgt_sr,
    output logic [DATA_W-1:0]          ow_result
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                          accept;
    logic                          q_push;
    logic                          q_pop;
    logic [CW-1:0]                 q_count;
    logic [GP_TGT_W-1:0]           q_head_tgt;
    logic [DATA_W-1:0]             q_head_data;
    logic [DEPTH-1:0]              q_ent_valid;
    logic [DEPTH-1:0][GP_TGT_W-1:0] q_ent_tgt;
    gp_src_e                       gp_src;

    // Ready depends only on registered occupancy, never on iw_valid
    assign mem.ow_ready = (q_count < CW'(DEPTH)) & iw_rst_n;
    assign accept       = mem.iw_valid & mem.ow_ready;

    // GP port arbitration: load return, then oldest queued write, then direct pipe write
    always_comb begin
        gp_src = GP_SRC_NONE;
        if (mem.iw_ld_valid)
            gp_src = GP_SRC_LD;
        else if (q_count != '0)
            gp_src = GP_SRC_Q;
        else if (accept & mem.iw_tgt_gp_we)
            gp_src = GP_SRC_PIPE;
    end

    // Drive the GP port from the selected source; reset forces it idle
    always_comb begin
        ow_gp_write_addr   = '0;
        ow_gp_write_data   = '0;
        ow_gp_write_enable = 1'b0;
        case (gp_src)
            GP_SRC_LD: begin
                ow_gp_write_addr = mem.iw_ld_tgt;
                ow_gp_write_data = mem.iw_ld_data;
            end
            GP_SRC_Q: begin
                ow_gp_write_addr = q_head_tgt;
                ow_gp_write_data = q_head_data;
            end
            GP_SRC_PIPE: begin
                ow_gp_write_addr = mem.iw_tgt_gp;
                ow_gp_write_data = mem.iw_result;
            end
            default: ;
        endcase
        ow_gp_write_enable = iw_rst_n & (gp_src != GP_SRC_NONE);
    end

    // A pipe write queues whenever it cannot go straight out, keeping program order
    assign q_push = accept & mem.iw_tgt_gp_we & (mem.iw_ld_valid | (q_count != '0));
    assign q_pop  = (gp_src == GP_SRC_Q);

    wb_gp_fifo #(
        .DEPTH  (DEPTH),
        .TGT_W  (GP_TGT_W),
        .DATA_W (DATA_W),
        .CW     (CW)
    ) u_fifo (
        .clk_i       (iw_clk),
        .rst_n_i     (iw_rst_n),
        .push_i      (q_push),
        .push_tgt_i  (mem.iw_tgt_gp),
        .push_data_i (mem.iw_result),
        .pop_i       (q_pop),
        .head_tgt_o  (q_head_tgt),
        .head_data_o (q_head_data),
        .count_o     (q_count),
        .ent_valid_o (q_ent_valid),
        .ent_tgt_o   (q_ent_tgt)
    );

    assign ow_q_count = q_count;

    // Pending mask: one bit per GP register with a queued, unwritten write
    always_comb begin
        ow_gp_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_ent_valid[i])
                ow_gp_pend[q_ent_tgt[i]] = 1'b1;
        end
    end

    // SR/AR ports are uncontended and pass straight through on accept
    assign ow_sr_write_addr   = mem.iw_tgt_sr;
    assign ow_sr_write_data   = mem.iw_sr_result;
    assign ow_sr_write_enable = accept & mem.iw_tgt_sr_we;
    assign ow_ar_write_addr   = mem.iw_tgt_ar;
    assign ow_ar_write_data   = mem.iw_ar_result;
    assign ow_ar_write_enable = accept & mem.iw_tgt_ar_we;

    // Retire record: latch on accept, pulse valid for one cycle
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            ow_retire_valid <= 1'b0;
            ow_pc           <= '0;
            ow_instr        <= '0;
            ow_opc          <= '0;
            ow_tgt_gp       <= '0;
            ow_tgt_sr       <= '0;
            ow_result       <= '0;
        end else begin
            ow_retire_valid <= accept;
            if (accept) begin
                ow_pc     <= mem.iw_pc;
                ow_instr  <= mem.iw_instr;
                ow_opc    <= mem.iw_opc;
                ow_tgt_gp <= mem.iw_tgt_gp;
                ow_tgt_sr <= mem.iw_tgt_sr;
                ow_result <= mem.iw_result;
            end
        end
    end

endmodule
